// File: rtl/block_spawn_scheduler_if.sv
// Signal bundle between the spawn scheduler and its block ROM, collision logic and renderer.
// The scheduler side uses the master modport; the surrounding system uses slave.
interface block_spawn_scheduler_if #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned TIME_W     = 16,
    parameter int unsigned MAX_ACTIVE = 4
);
    localparam int unsigned ENTRY_W = TIME_W + 27;
    localparam int unsigned SEL_W   = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;

    logic                  start_in;
    logic                  pause_in;
    logic [ADDR_W-1:0]     rom_addr_out;
    logic [ENTRY_W-1:0]    rom_data_in;
    logic [MAX_ACTIVE-1:0] hit_in;
    logic [SEL_W-1:0]      slot_sel_in;
    logic [ENTRY_W-1:0]    slot_data_out;
    logic [MAX_ACTIVE-1:0] slot_valid_out;
    logic [TIME_W-1:0]     curr_time_out;
    logic [7:0]            hit_count_out;
    logic [7:0]            miss_count_out;
    logic                  busy_out;
    logic                  done_out;

    modport master (
        input  start_in, pause_in, rom_data_in, hit_in, slot_sel_in,
        output rom_addr_out, slot_data_out, slot_valid_out, curr_time_out,
        output hit_count_out, miss_count_out, busy_out, done_out
    );

    modport slave (
        output start_in, pause_in, rom_data_in, hit_in, slot_sel_in,
        input  rom_addr_out, slot_data_out, slot_valid_out, curr_time_out,
        input  hit_count_out, miss_count_out, busy_out, done_out
    );
endinterface

// File: rtl/block_spawn_scheduler.sv
// Beat-map sequencer: owns the game clock, streams blocks from ROM into a few active
// slots ahead of their hit time, and retires them on a hit or a miss timeout.
module block_spawn_scheduler #(
    parameter int unsigned NUM_BLOCKS  = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned MAX_ACTIVE  = 4,
    parameter int unsigned TICK_CYCLES = 10,
    parameter int unsigned LOOKAHEAD   = 100,
    parameter int unsigned MISS_WINDOW = 5
) (
    input logic clk_in,
    input logic rst_in,
    block_spawn_scheduler_if.master bus
);
    localparam int unsigned ENTRY_W = TIME_W + 27;
    localparam int unsigned SEL_W   = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;
    localparam int unsigned TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_ACTIVE + 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StStage, StDone} state_e;

    state_e                state;
    logic [ADDR_W:0]       idx;
    logic                  wait_cnt;
    logic [TICK_W-1:0]     tick;
    logic [TIME_W-1:0]     curr_time;
    logic [ENTRY_W-1:0]    staged;
    logic [ENTRY_W-1:0]    slots [MAX_ACTIVE];
    logic [MAX_ACTIVE-1:0] valid;
    logic [7:0]            hit_cnt;
    logic [7:0]            miss_cnt;

    logic                  busy;
    logic [MAX_ACTIVE-1:0] hit_ret;
    logic [MAX_ACTIVE-1:0] miss_ret;
    logic [MAX_ACTIVE-1:0] valid_next;
    logic [CNT_W-1:0]      hit_n;
    logic [CNT_W-1:0]      miss_n;
    logic                  free_found;
    logic [SEL_W-1:0]      free_idx;
    logic [TIME_W-1:0]     staged_time;
    logic                  at_end;
    logic                  due;
    logic                  place;
    logic [8:0]            hit_sum;
    logic [8:0]            miss_sum;

    assign busy        = (state == StFetch) || (state == StWait) || (state == StStage);
    assign staged_time = staged[ENTRY_W-1 -: TIME_W];
    assign at_end      = (staged_time == '1) || (idx == (ADDR_W+1)'(NUM_BLOCKS));
    // Extra bit keeps curr_time + LOOKAHEAD from wrapping near the top of the time range.
    assign due   = {1'b0, staged_time} <= ({1'b0, curr_time} + (TIME_W+1)'(LOOKAHEAD));
    assign place = (state == StStage) && !at_end && due && free_found;

    always_comb begin
        hit_ret    = bus.hit_in & valid;
        miss_ret   = '0;
        hit_n      = '0;
        miss_n     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(MAX_ACTIVE); i++) begin
            // A hit on the same slot wins over a miss.
            miss_ret[i] = valid[i] && !hit_ret[i] && !bus.pause_in &&
                ({1'b0, curr_time} >
                 ({1'b0, slots[i][ENTRY_W-1 -: TIME_W]} + (TIME_W+1)'(MISS_WINDOW)));
            hit_n  = hit_n + CNT_W'(hit_ret[i]);
            miss_n = miss_n + CNT_W'(miss_ret[i]);
        end
        // Free slots come from the registered valid bits, so a slot freed this cycle waits.
        for (int i = int'(MAX_ACTIVE) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = SEL_W'(i);
            end
        end
        valid_next = valid & ~(hit_ret | miss_ret);
        if (place) begin
            valid_next[free_idx] = 1'b1;
        end
        hit_sum  = {1'b0, hit_cnt} + 9'(hit_n);
        miss_sum = {1'b0, miss_cnt} + 9'(miss_n);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= StIdle;
            idx       <= '0;
            wait_cnt  <= 1'b0;
            tick      <= '0;
            curr_time <= '0;
            staged    <= '0;
            valid     <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            for (int i = 0; i < int'(MAX_ACTIVE); i++) begin
                slots[i] <= '0;
            end
        end else begin
            valid    <= valid_next;
            hit_cnt  <= hit_sum[8] ? 8'hFF : hit_sum[7:0];
            miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
            if (place) begin
                slots[free_idx] <= staged;
            end
            if (busy && !bus.pause_in) begin
                if (tick == TICK_W'(TICK_CYCLES - 1)) begin
                    tick <= '0;
                    if (curr_time != '1) begin
                        curr_time <= curr_time + TIME_W'(1);
                    end
                end else begin
                    tick <= tick + TICK_W'(1);
                end
            end
            unique case (state)
                StIdle: begin
                    if (bus.start_in) begin
                        state <= StFetch;
                    end
                end
                StFetch: begin
                    wait_cnt <= 1'b0;
                    state    <= StWait;
                end
                StWait: begin
                    if (wait_cnt) begin
                        staged <= bus.rom_data_in;
                        state  <= StStage;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                StStage: begin
                    if (at_end) begin
                        if (valid == '0) begin
                            state <= StDone;
                        end
                    end else if (place) begin
                        idx   <= idx + (ADDR_W+1)'(1);
                        state <= StFetch;
                    end
                end
                StDone: begin
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.rom_addr_out   = idx[ADDR_W-1:0];
    assign bus.slot_data_out  = slots[bus.slot_sel_in];
    assign bus.slot_valid_out = valid;
    assign bus.curr_time_out  = curr_time;
    assign bus.hit_count_out  = hit_cnt;
    assign bus.miss_count_out = miss_cnt;
    assign bus.busy_out       = busy;
    assign bus.done_out       = (state == StDone);
endmodule

// File: doc/block_spawn_scheduler.md
Name: block_spawn_scheduler

Overview:
Sequences the beat-map for the game logic and renderer. It owns the game clock (curr_time) and walks a block-list ROM in time order. Each block is loaded into a small table of active slots LOOKAHEAD time units before its hit time. Slots are retired on a hit from collision logic or on a miss timeout. The renderer and collision logic read slot contents through a selectable read port.

Parameters:
NUM_BLOCKS, 64, max entries in block ROM
ADDR_W, 6, ROM address width
TIME_W, 16, curr_time / block time width
MAX_ACTIVE, 4, number of active block slots
TICK_CYCLES, 10, clk cycles per curr_time increment
LOOKAHEAD, 100, time units before hit time that a block is spawned
MISS_WINDOW, 5, time units after hit time before a block is counted as missed

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
start_in  in  1  pulse; begins the song from IDLE
pause_in  in  1  level; freezes tick counter, curr_time, and miss detection
rom_addr_out  out  ADDR_W  block ROM address
rom_data_in  in  TIME_W+27  {time[TIME_W], x[12], y[12], color[1], dir[2]}; valid 2 cycles after address
hit_in  in  MAX_ACTIVE  per-slot hit pulse from collision logic
slot_sel_in  in  log2(MAX_ACTIVE)  slot read select
slot_data_out  out  TIME_W+27  selected slot contents (combinational read)
slot_valid_out  out  MAX_ACTIVE  per-slot valid
curr_time_out  out  TIME_W  game time
hit_count_out  out  8  saturating hit counter
miss_count_out  out  8  saturating miss counter
busy_out  out  1  high in every state except IDLE and DONE
done_out  out  1  song finished

Behaviour:
- Reset values: all outputs 0; state=IDLE; tick counter=0; ROM index=0; staging register empty.
- Tick counter and curr_time:
  - Tick counter runs only while busy_out=1 and pause_in=0.
  - At count TICK_CYCLES-1 the counter wraps to 0 and curr_time increments by 1.
  - curr_time saturates at all-ones.
- FSM states: IDLE, FETCH, WAIT, STAGE, DONE.
  - IDLE: on start_in go to FETCH. start_in is ignored in every other state.
  - FETCH: drive rom_addr_out=index. Go to WAIT.
  - WAIT: wait 2 cycles, then latch rom_data_in into the staging register and go to STAGE.
  - STAGE, end of list: if staged time == all-ones (sentinel) or index == NUM_BLOCKS, stop fetching and hold until no slot is valid, then go to DONE.
  - STAGE, placement: when staged time <= curr_time+LOOKAHEAD and a free slot exists, write the staged entry into the lowest-index free slot. Set that slot's valid bit, increment index, and go to FETCH.
  - STAGE, otherwise: hold.
  - DONE: done_out=1. curr_time is frozen. Leave DONE only by reset.
- The LOOKAHEAD comparison uses TIME_W+1 bits to avoid wrap-around. Blocks already past due (time < curr_time) are still placed and become subject to the miss check.
- Retirement, hit: hit_in[i] while valid[i]=1 clears the slot next cycle and adds 1 to hit_count_out. hit_in on an invalid slot is ignored.
- Retirement, miss: while not paused, valid[i] and curr_time > time[i]+MISS_WINDOW clears the slot and adds 1 to miss_count_out.
- Simultaneous events:
  - Hit and miss on the same slot in the same cycle counts as a hit only.
  - Multiple hits in one cycle increment hit_count_out by their popcount. Misses are counted the same way.
  - A slot freed in cycle N cannot be allocated before cycle N+1.
  - Both counters saturate at 255.
- Reset mid-operation returns everything to the reset values on the next edge. Slot contents are cleared and in-flight ROM data is discarded.

Test Plan:
- Reset then idle: hold start_in low for 100 cycles. curr_time_out=0, busy_out=0, slot_valid_out=0, rom_addr_out=0.
- Tick rate: pulse start_in with ROM[0]=sentinel. DONE is reached within 5 cycles and curr_time stays 0. With ROM[0].time=500: after 60 cycles curr_time=6. Toggling pause_in for 30 cycles then adds 0 to curr_time.
- Spawn timing: ROM times {150, 160, sentinel}. Slot0 becomes valid exactly when curr_time reaches 50, and slot1 when it reaches 60. rom_addr_out steps 0→1→2.
- Hit: with slot0 holding time 150, pulse hit_in=4'b0001 at curr_time=149. Next cycle valid[0]=0 and hit_count_out=1. Pulse hit_in on an empty slot: no change.
- Miss plus slot full: 5 blocks all at time 100. Slots 0-3 fill and the 5th waits in staging. At curr_time=106 all four miss (miss_count_out=4). The 5th is placed into slot0 the following cycle and misses on the next cycle (miss_count_out=5). DONE follows.
- Reset mid-song: assert rst_in for one cycle at curr_time=75 with 2 slots valid. Next cycle all outputs are 0 and state is IDLE. A new start_in restarts fetching from index 0.
